// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute control unit.
// Fetch runs T0-T2 and execute runs T3-T5. MUL/DIV add a T6 for the HI word.
// Strobes are decoded from the current state, and from IR where needed, so every
// strobe belongs to the current T-state. T1 also looks at mem_ready.
// Build option: define MULDIV_SEQ_EN to decode MUL/DIV and enable the T6 state.
// When it is undefined, MUL/DIV opcodes are illegal, and MUL, DIV, HIin, LOin
// and Zhighout stay at 0.
module control_sequencer (
  input  logic        Clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        RZin,
  output logic        Read,
  output logic        MDRin,
  output logic        PCin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        IRin,
  output logic        MDRout,
  output logic        RYin,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] GPRin,
  output logic [15:0] GPRout,
  output logic        ADD,
  output logic        SUB,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        AND,
  output logic        OR,
  output logic        MUL,
  output logic        DIV,
  output logic        NEGATE,
  output logic        NOT,
  output logic        run,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned REG_W = 16;
  localparam int unsigned ALU_W = 12;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned IDX_W = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ALU select bit order: {ADD,SUB,SHR,SHL,ROR,ROL,AND,OR,MUL,DIV,NEGATE,NOT}
  localparam logic [ALU_W-1:0] ALU_ADD = 12'h800;
  localparam logic [ALU_W-1:0] ALU_SUB = 12'h400;
  localparam logic [ALU_W-1:0] ALU_SHR = 12'h200;
  localparam logic [ALU_W-1:0] ALU_SHL = 12'h100;
  localparam logic [ALU_W-1:0] ALU_ROR = 12'h080;
  localparam logic [ALU_W-1:0] ALU_ROL = 12'h040;
  localparam logic [ALU_W-1:0] ALU_AND = 12'h020;
  localparam logic [ALU_W-1:0] ALU_OR  = 12'h010;
  localparam logic [ALU_W-1:0] ALU_NEG = 12'h002;
  localparam logic [ALU_W-1:0] ALU_NOT = 12'h001;

`ifdef MULDIV_SEQ_EN
  localparam logic [OP_W-1:0]  OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0]  OP_DIV  = 5'b10000;
  localparam logic [ALU_W-1:0] ALU_MUL = 12'h008;
  localparam logic [ALU_W-1:0] ALU_DIV = 12'h004;
  logic op_muldiv;
`endif

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [OP_W-1:0]  opcode;
  logic [IDX_W-1:0] ra;
  logic [IDX_W-1:0] rb;
  logic [IDX_W-1:0] rc;
  logic [REG_W-1:0] ra_oh;
  logic [REG_W-1:0] rb_oh;
  logic [REG_W-1:0] rc_oh;
  logic [ALU_W-1:0] alu_sel;
  logic             op_legal;
  logic             op_unary;
  logic             op_halt;
  logic             ir_unused;

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];
  assign ra_oh  = REG_W'(1) << ra;
  assign rb_oh  = REG_W'(1) << rb;
  assign rc_oh  = REG_W'(1) << rc;
  // The low IR bits hold immediates/offsets that this sequencer does not use.
  assign ir_unused = ^IR[14:0];

  // State register
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Opcode decode: ALU select, operand form, and legality
  always_comb begin
    alu_sel  = '0;
    op_legal = 1'b1;
    op_unary = 1'b0;
    op_halt  = 1'b0;
`ifdef MULDIV_SEQ_EN
    op_muldiv = 1'b0;
`endif
    case (opcode)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_SHR:  alu_sel = ALU_SHR;
      OP_SHL:  alu_sel = ALU_SHL;
      OP_ROR:  alu_sel = ALU_ROR;
      OP_ROL:  alu_sel = ALU_ROL;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      OP_NEG:  begin alu_sel = ALU_NEG; op_unary = 1'b1; end
      OP_NOT:  begin alu_sel = ALU_NOT; op_unary = 1'b1; end
`ifdef MULDIV_SEQ_EN
      OP_MUL:  begin alu_sel = ALU_MUL; op_muldiv = 1'b1; end
      OP_DIV:  begin alu_sel = ALU_DIV; op_muldiv = 1'b1; end
`endif
      OP_HALT: op_halt = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Next-state and per-state strobe decode
  always_comb begin
    state_nxt = state;
    {PCout, MARin, IncPC, RZin, Read, MDRin, PCin, Zlowout, Zhighout,
     IRin, MDRout, RYin, HIin, LOin} = '0;
    {ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT} = '0;
    GPRin   = '0;
    GPRout  = '0;
    done    = 1'b0;
    illegal = 1'b0;
    run     = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Read = 1'b1;
        if (mem_ready) begin
          MDRin = 1'b1; Zlowout = 1'b1; PCin = 1'b1;
          state_nxt = S_T2;
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        if (op_halt)        state_nxt = S_IDLE;
        else if (!op_legal) begin illegal = 1'b1; state_nxt = S_T0; end
        else                state_nxt = S_T3;
      end
      S_T3: begin
        GPRout = rb_oh; RYin = 1'b1;
        state_nxt = S_T4;
      end
      S_T4: begin
        RZin = 1'b1;
        {ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT} = alu_sel;
        GPRout = op_unary ? rb_oh : rc_oh;
        state_nxt = S_T5;
      end
      S_T5: begin
`ifdef MULDIV_SEQ_EN
        if (op_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
          state_nxt = S_T6;
        end else
`endif
        begin
          Zlowout = 1'b1; GPRin = ra_oh; done = 1'b1;
          state_nxt = stop ? S_IDLE : S_T0;
        end
      end
`ifdef MULDIV_SEQ_EN
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
        state_nxt = stop ? S_IDLE : S_T0;
      end
`else
      S_T6: state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
